// File: rtl/period_generator.sv
// Programmable square-wave source. A job emits n_prd periods of prd ms each
// (or runs until stopped when n_prd=0), then pulses done_tick.
//
// state | meaning
// IDLE  | waiting for start, ready=1
// HIGH  | high phase of the current period, so=1
// LOW   | low phase of the current period, end-of-job decision at its end
// DONE  | one-cycle completion; err_tick also set if prd was rejected
module period_generator #(
  parameter int CLK_MS_COUNT = 50000,
  parameter int PW           = 10,
  parameter int NW           = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [PW-1:0] prd,
  input  logic [NW-1:0] n_prd,
  input  logic          stop,
  output logic          ready,
  output logic          so,
  output logic          done_tick,
  output logic          err_tick
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

  localparam logic [15:0] T_LAST = 16'(CLK_MS_COUNT - 1);

  state_t        state_q, state_d;
  logic [15:0]   t_q, t_d;
  logic [PW-1:0] m_q, m_d;
  logic [NW-1:0] c_q, c_d;
  logic [PW-1:0] p_lat_q, p_lat_d;
  logic [NW-1:0] n_lat_q, n_lat_d;
  logic          stop_pend_q, stop_pend_d;
  logic          err_q, err_d;

  logic [PW-1:0] h_len, l_len, phase_len;
  logic          ms_end, phase_end;

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    m_d         = m_q;
    c_d         = c_q;
    p_lat_d     = p_lat_q;
    n_lat_d     = n_lat_q;
    stop_pend_d = stop_pend_q;
    err_d       = err_q;

    // Odd periods put the extra millisecond in the low phase.
    h_len     = p_lat_q >> 1;
    l_len     = p_lat_q - h_len;
    phase_len = (state_q == HIGH) ? h_len : l_len;
    ms_end    = (t_q == T_LAST);
    phase_end = ms_end && (m_q == phase_len - PW'(1));

    case (state_q)
      IDLE: begin
        err_d = 1'b0;
        if (start) begin
          p_lat_d     = prd;
          n_lat_d     = n_prd;
          c_d         = n_prd;
          t_d         = '0;
          m_d         = '0;
          stop_pend_d = 1'b0;
          if (prd < PW'(2)) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = HIGH;
          end
        end
      end
      HIGH, LOW: begin
        if (stop) stop_pend_d = 1'b1;
        if (ms_end) begin
          t_d = '0;
          m_d = m_q + PW'(1);
        end else begin
          t_d = t_q + 16'd1;
        end
        if (phase_end) begin
          t_d = '0;
          m_d = '0;
          if (state_q == HIGH) begin
            state_d = LOW;
          end else if (stop_pend_q || stop ||
                       (n_lat_q != '0 && c_q == NW'(1))) begin
            state_d = DONE;
          end else begin
            if (n_lat_q != '0) c_d = c_q - NW'(1);
            state_d = HIGH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      t_q         <= '0;
      m_q         <= '0;
      c_q         <= '0;
      p_lat_q     <= '0;
      n_lat_q     <= '0;
      stop_pend_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      m_q         <= m_d;
      c_q         <= c_d;
      p_lat_q     <= p_lat_d;
      n_lat_q     <= n_lat_d;
      stop_pend_q <= stop_pend_d;
      err_q       <= err_d;
    end
  end

  assign so        = (state_q == HIGH);
  assign ready     = (state_q == IDLE);
  assign done_tick = (state_q == DONE);
  assign err_tick  = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_period_generator.sv
// Directed bench for period_generator with a 4-cycle millisecond so that
// waveforms can be checked cycle by cycle against a small reference model.
module tb_period_generator;
  localparam int C  = 4;
  localparam int PW = 10;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          reset, start, stop;
  logic [PW-1:0] prd;
  logic [NW-1:0] n_prd;
  logic          ready, so, done_tick, err_tick;
  logic [3:0]    obs;

  int n_cmp = 0;
  int n_bad = 0;

  period_generator #(.CLK_MS_COUNT(C), .PW(PW), .NW(NW)) dut (
    .clk(clk), .reset(reset), .start(start), .prd(prd), .n_prd(n_prd),
    .stop(stop), .ready(ready), .so(so), .done_tick(done_tick),
    .err_tick(err_tick)
  );

  always #5 clk = ~clk;

  assign obs = {ready, so, done_tick, err_tick};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {ready, so, done_tick, err_tick} j cycles after the accept edge.
  function automatic logic [3:0] model(input int j, input int p, input int total);
    int pc;
    if (p < 2) return (j == 0) ? 4'b0011 : 4'b1000;
    pc = p * C;
    if (j < total * pc) return {1'b0, ((j % pc) < (p / 2) * C), 2'b00};
    if (j == total * pc) return 4'b0010;
    return 4'b1000;
  endfunction

  task automatic run_job(input int p, input int n, input int total,
                         input int stop_j, input int start_j, input string tag);
    int last;
    prd   = PW'(p);
    n_prd = NW'(n);
    start = 1'b1;
    step();
    start = 1'b0;
    prd   = PW'(p + 3);
    n_prd = NW'(n + 5);
    last  = (p < 2) ? 1 : total * p * C + 1;
    for (int j = 0; j <= last; j++) begin
      check($sformatf("%s j=%0d", tag, j), 32'(obs), 32'(model(j, p, total)));
      if (j == stop_j) stop = 1'b1;
      if (j == start_j) begin
        start = 1'b1;
        prd   = PW'(3);
        n_prd = NW'(1);
      end
      step();
      stop  = 1'b0;
      start = 1'b0;
    end
  endtask

  initial begin
    int edges[$];
    int dones;
    logic prev_so;

    reset = 1'b0;
    start = 1'b1;
    stop  = 1'b0;
    prd   = PW'(5);
    n_prd = NW'(2);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("reset_hold %0d", i), 32'(obs), 32'h8);
    end
    reset = 1'b1;
    start = 1'b0;
    step();
    check("reset_release", 32'(obs), 32'h8);

    run_job(5, 2, 2, -1, -1, "prd5_n2");
    run_job(2, 1, 1, -1, 2, "prd2_n1_start_ignored");
    run_job(1, 3, 0, -1, -1, "prd1_reject");
    run_job(6, 0, 3, 50, -1, "prd6_cont_stop");

    prd   = PW'(6);
    n_prd = NW'(0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("rerun_high", 32'(so), 32'd1);
    reset = 1'b0;
    step();
    check("reset_mid_high", 32'(obs), 32'h8);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (done_tick || so || !ready) dones++;
    end
    check("post_reset_quiet", 32'(dones), 32'd0);

    prd     = PW'(7);
    n_prd   = NW'(3);
    start   = 1'b1;
    prev_so = 1'b0;
    dones   = 0;
    step();
    start = 1'b0;
    for (int j = 0; j < 3 * 7 * C + 6; j++) begin
      if (so && !prev_so) edges.push_back(j);
      if (done_tick) dones++;
      prev_so = so;
      step();
    end
    check("loop_edges", 32'(edges.size()), 32'd3);
    if (edges.size() == 3) begin
      check("loop_prd_1", 32'((edges[1] - edges[0]) / C), 32'd7);
      check("loop_prd_2", 32'((edges[2] - edges[1]) / C), 32'd7);
      check("loop_rem", 32'((edges[2] - edges[0]) % C), 32'd0);
    end
    check("loop_dones", 32'(dones), 32'd1);
    check("loop_ready", 32'(ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/period_generator.md
Name: period_generator

Overview:
Programmable square-wave source: the transmit-side counterpart of the period counter. On a start handshake it latches a period in milliseconds and a repeat count. It then drives a square wave whose rising edges are exactly prd ms apart, and reports completion. It provides stimulus for the measurement path and a board-level test tone, and looped back it reads back on the period counter as the same prd.

Parameters:
CLK_MS_COUNT, 50000, clock cycles per millisecond (50 MHz clock)
PW, 10, width of the period field in ms
NW, 8, width of the repeat-count field

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset; sampled on rising edge of clk
start  input  1  request; accepted only when ready=1
prd  input  PW  period in ms; valid 2..2^PW-1; latched at accept
n_prd  input  NW  number of periods to emit; 0 = continuous until stop; latched at accept
stop  input  1  single-cycle request to end continuous/multi-period output
ready  output  1  high in idle only
so  output  1  generated square wave
done_tick  output  1  one-cycle pulse when a job ends (normal, stopped or rejected)
err_tick  output  1  one-cycle pulse coincident with done_tick when prd<2 was rejected

Behaviour:
- Reset (reset=0 at a clock edge): state=idle, so=0, ready=1, done_tick=0, err_tick=0, all counters and stop_pend cleared. Applies mid-operation; so is 0 from the next edge and no done_tick is issued.
- Registers: t_reg (16b ms prescaler, 0..CLK_MS_COUNT-1), m_reg (PW-bit ms within phase), c_reg (NW-bit periods remaining), p_lat, n_lat, stop_pend, state (2b).
- Outputs are Moore: so=(state==HIGH), ready=(state==IDLE), done_tick=(state==DONE), err_tick=(state==DONE && err_reg).
- Phase lengths: H = p_lat>>1 ms high, L = p_lat-H ms low (odd prd puts the extra ms in low). Rising-edge spacing = p_lat*CLK_MS_COUNT cycles exactly.
- IDLE: on start=1 at edge k, latch prd/n_prd and clear t/m/stop_pend.
  - If prd<2: go to DONE with err_reg=1.
  - Else: go to HIGH, so so=1 from edge k+1.
  - start while not IDLE is ignored.
- HIGH: t counts each cycle. On t==CLK_MS_COUNT-1, t wraps to 0 and m increments. When the last ms of H completes, clear t and m and go to LOW. HIGH lasts exactly H*CLK_MS_COUNT cycles.
- LOW: same counting for L ms. At the end of the phase:
  - If stop_pend, or (n_lat!=0 and c_reg==1): go to DONE.
  - Else: decrement c_reg (when n_lat!=0) and go to HIGH.
- c_reg is loaded with n_lat at accept. n_lat=0 never decrements.
- stop: sets stop_pend in HIGH or LOW. The current period always completes, so no runt pulses. stop in IDLE/DONE is ignored. stop coincident with the final period's end gives a single DONE.
- DONE: one cycle, so=0, done_tick=1. Then go to IDLE; err_reg clears.
- Latency: accept to first rising edge = 1 cycle. Final falling-edge-to-low-end to done_tick = 1 cycle after the last low cycle. Total for n periods = 1 + n*prd*CLK_MS_COUNT cycles from accept edge to the done_tick cycle.
- prd/n_prd changes after accept have no effect. Counter widths must not overflow at prd=2^PW-1.

Test Plan:
- Reset: hold reset=0 three cycles with start=1 -> so=0, ready=1, done_tick=0, err_tick=0. Release -> idle, start now accepted.
- CLK_MS_COUNT=4, prd=5, n_prd=2 -> so high 8, low 12, high 8, low 12 cycles. done_tick single cycle at 41st cycle after accept, then ready=1.
- CLK_MS_COUNT=4, prd=2, n_prd=1 -> so high 4, low 4. Start pulsed during output is ignored; exactly one done_tick.
- prd=1, n_prd=3 -> so stays 0. done_tick=1 and err_tick=1 on the cycle after accept; ready=1 the cycle after.
- CLK_MS_COUNT=4, prd=6, n_prd=0, stop pulsed during the 3rd high phase -> 3rd period completes (12 high/12 low), done_tick, no 4th rising edge. Reset=0 mid-high on a rerun -> so=0 next edge, no done_tick.
- Loopback so into the period counter with CLK_MS_COUNT equal, prd=7, n_prd=3 -> counter reports prd=7.
